rl_ram_1rw_arb2: RTL
====================

RL_RAM_1RW_ARB2 -- requirements
Module: rl_ram_1rw_arb2

Interface
REQ-001 SHALL have parameter ABITS, default 10, RAM address bits.
REQ-002 SHALL have parameter DBITS, default 32, RAM data bits; BBITS=(DBITS+7)/8 byte enables.
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_i[2] input 1 each, requester p asks for the RAM.
REQ-006 SHALL have ports gnt_o[2] output 1 each, access accepted this cycle.
REQ-007 SHALL have ports addr_i[2] ABITS, we_i[2] 1, be_i[2] BBITS, din_i[2] DBITS, all inputs, per-requester command.
REQ-008 SHALL have ports rvalid_o[2] output 1 and rdata_o[2] output DBITS, per-requester read response.
REQ-009 SHALL have RAM-side outputs ram_addr_o ABITS, ram_we_o 1, ram_be_o BBITS, ram_din_o DBITS; input ram_dout_i DBITS (1-cycle registered read).

Function
REQ-010 SHALL grant at most one requester per cycle; gnt_o combinational from req_i and arbitration state.
REQ-011 SHALL arbitrate round-robin: a single requester wins immediately; on conflict the requester not granted most recently wins.
REQ-012 SHALL drive ram_* from the granted requester's command; with no grant ram_we_o=0, ram_be_o=0, ram_addr_o holds its last value.
REQ-013 SHALL treat a command as transferred when req_i[p] && gnt_o[p]; requester must hold the command stable until granted.
REQ-014 SHALL register, for a granted read (we_i=0), the owner index and a read flag; next cycle assert rvalid_o[owner] for exactly one cycle with rdata_o[owner]=ram_dout_i.
REQ-015 SHALL keep rdata_o[p] stable when rvalid_o[p]=0 (last read data held).
REQ-016 SHALL not assert rvalid_o for writes; write data reaches RAM in the grant cycle.
REQ-017 SHALL sustain one transfer per cycle; back-to-back reads from alternating requesters each return data exactly one cycle after their grant.
REQ-018 SHALL update the round-robin pointer only on a grant; idle cycles leave it unchanged.

Reset
REQ-019 SHALL on rst_ni low asynchronously clear: pointer to "requester 1 last" (requester 0 wins first conflict), rvalid_o=0, rdata_o=0, ram_addr_o=0, lock state IDLE.
REQ-020 SHALL drop an in-flight read response when reset asserts mid-operation; no rvalid_o after release.

Configuration
REQ-021 SHALL support macro RL_RAM_ARB_LOCK_EN adding inputs lock_i[2] (1 bit each).
REQ-022 With RL_RAM_ARB_LOCK_EN: FSM IDLE->LOCKED(p) when requester p is granted with lock_i[p]=1; in LOCKED(p) only p may be granted; LOCKED->IDLE on a grant to p with lock_i[p]=0 or when req_i[p]=0.
REQ-023 Without RL_RAM_ARB_LOCK_EN: no lock ports, no lock FSM, pure round-robin.

Structure
REQ-024 SHALL place in package rl_ram_arb_pkg: requester-index typedef, lock FSM state enum (IDLE, LOCKED), NUM_REQ=2 constant.
REQ-025 SHALL implement the 2-way round-robin grant/pointer in sub-module rl_rr_arb2; datapath muxing and response routing stay in the top.

Verification
REQ-026 Reset then req_i[0]=1 read addr 0x005 alone -> gnt_o[0]=1 same cycle; rvalid_o[0]=1 next cycle with rdata_o[0]=mem[0x005].
REQ-027 Both requesters continuously request reads 0x010/0x020 -> grants alternate 0,1,0,1; each rvalid_o one cycle after its grant with correct data.
REQ-028 Requester 1 writes 0xDEADBEEF be=4'b0011 to 0x033, then requester 0 reads 0x033 -> rdata_o[0] low 16 bits 0xBEEF, upper bytes unchanged; no rvalid_o for the write.
REQ-029 Assert rst_ni low in the cycle after a granted read -> rvalid_o stays 0 after release; pointer back to reset value.
REQ-030 With RL_RAM_ARB_LOCK_EN, requester 0 locks for 3 grants while requester 1 requests -> gnt_o[1]=0 for those 3 cycles, granted the cycle after the unlocking grant.

Source files
------------

// File: rtl/rl_ram_1rw_arb2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package   : rl_ram_arb_pkg                                          |
// | Brief     : Shared types for the two-port RAM arbiter: requester    |
// |             index, lock FSM states, requester count.                |
// | Revision  : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package rl_ram_arb_pkg;

   localparam int NUM_REQ = 2;

   // One bit is enough to name either of the two requesters.
   typedef logic [0:0] req_idx_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/rl_ram_1rw_arb2_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : rl_ram_1rw_arb2_if                                      |
// | Brief     : Requester-side command/response bundle for both         |
// |             requesters. Names are seen from the arbiter (slave).    |
// |             lock_i exists only when RL_RAM_ARB_LOCK_EN is defined.  |
// | Revision  : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface rl_ram_1rw_arb2_if #(
   parameter int ABITS = 10,
   parameter int DBITS = 32,
   parameter int BBITS = (DBITS + 7) / 8
);
   import rl_ram_arb_pkg::*;

   logic [NUM_REQ-1:0]            req_i;
   logic [NUM_REQ-1:0]            gnt_o;
   logic [NUM_REQ-1:0][ABITS-1:0] addr_i;
   logic [NUM_REQ-1:0]            we_i;
   logic [NUM_REQ-1:0][BBITS-1:0] be_i;
   logic [NUM_REQ-1:0][DBITS-1:0] din_i;
   logic [NUM_REQ-1:0]            rvalid_o;
   logic [NUM_REQ-1:0][DBITS-1:0] rdata_o;
`ifdef RL_RAM_ARB_LOCK_EN
   logic [NUM_REQ-1:0]            lock_i;

   modport master (
      output req_i, addr_i, we_i, be_i, din_i, lock_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, din_i, lock_i,
      output gnt_o, rvalid_o, rdata_o
   );
`else
   modport master (
      output req_i, addr_i, we_i, be_i, din_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, din_i,
      output gnt_o, rvalid_o, rdata_o
   );
`endif

endinterface
`default_nettype wire

// File: rtl/rl_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : rl_rr_arb2                                              |
// | Brief     : Two-way round-robin arbiter. Grant is combinational;    |
// |             the "last winner" pointer moves only on a grant.        |
// | Revision  : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module rl_rr_arb2
   import rl_ram_arb_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   req_idx_t last_q;
   req_idx_t last_d;

   // Lone requester wins outright; on conflict the one not served last wins.
   always_comb begin
      gnt_o = '0;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_q == 1'b1) ? 2'b01 : 2'b10;
         default: gnt_o = '0;
      endcase
      last_d = last_q;
      if (|gnt_o) begin
         last_d = req_idx_t'(gnt_o[1]);
      end
   end

   // Pointer resets to "requester 1 last" so requester 0 wins the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rl_ram_1rw_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : rl_ram_1rw_arb2                                         |
// | Brief     : Shares one single-port RAM (1-cycle registered read)    |
// |             between two requesters. Round-robin grant, command mux, |
// |             read response routed back to its owner one cycle later. |
// |             Optional bus locking with macro RL_RAM_ARB_LOCK_EN.     |
// | Revision  : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module rl_ram_1rw_arb2
   import rl_ram_arb_pkg::*;
#(
   parameter  int ABITS = 10,
   parameter  int DBITS = 32,
   localparam int BBITS = (DBITS + 7) / 8
)(
   input  logic              clk_i,
   input  logic              rst_ni,
   rl_ram_1rw_arb2_if.slave  bus,
   output logic [ABITS-1:0]  ram_addr_o,
   output logic              ram_we_o,
   output logic [BBITS-1:0]  ram_be_o,
   output logic [DBITS-1:0]  ram_din_o,
   input  logic [DBITS-1:0]  ram_dout_i
);

   logic [NUM_REQ-1:0]            arb_req;
   logic [NUM_REQ-1:0]            gnt;
   req_idx_t                      sel;
   logic                          any_gnt;

   logic [ABITS-1:0]              addr_hold_q;
   logic                          rd_pend_q;
   req_idx_t                      rd_owner_q;
   logic [NUM_REQ-1:0][DBITS-1:0] rdata_hold_q;
   logic [NUM_REQ-1:0]            rvalid;

`ifdef RL_RAM_ARB_LOCK_EN
   lock_state_e lock_st_q;
   lock_state_e lock_st_d;
   req_idx_t    lock_own_q;
   req_idx_t    lock_own_d;

   // While locked only the owner is visible to the arbiter.
   always_comb begin
      for (int p = 0; p < NUM_REQ; p++) begin
         arb_req[p] = bus.req_i[p] &&
                      ((lock_st_q == IDLE) || (lock_own_q == req_idx_t'(p)));
      end
   end

   // Lock is taken by a locking grant and released by an unlocking grant or by the owner going idle.
   always_comb begin
      lock_st_d  = lock_st_q;
      lock_own_d = lock_own_q;
      case (lock_st_q)
         IDLE: begin
            if (any_gnt && bus.lock_i[sel]) begin
               lock_st_d  = LOCKED;
               lock_own_d = sel;
            end
         end
         LOCKED: begin
            if (!bus.req_i[lock_own_q] ||
                (gnt[lock_own_q] && !bus.lock_i[lock_own_q])) begin
               lock_st_d = IDLE;
            end
         end
         default: lock_st_d = IDLE;
      endcase
   end

   // Lock state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_st_q  <= IDLE;
         lock_own_q <= '0;
      end else begin
         lock_st_q  <= lock_st_d;
         lock_own_q <= lock_own_d;
      end
   end
`else
   assign arb_req = bus.req_i;
`endif

   rl_rr_arb2 u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (arb_req),
      .gnt_o  (gnt)
   );

   assign bus.gnt_o = gnt;
   assign any_gnt   = |gnt;
   assign sel       = req_idx_t'(gnt[1]);

   // Granted command goes straight to the RAM; address parks on its last value when idle.
   assign ram_addr_o = any_gnt ? bus.addr_i[sel] : addr_hold_q;
   assign ram_we_o   = any_gnt & bus.we_i[sel];
   assign ram_be_o   = any_gnt ? bus.be_i[sel] : '0;
   assign ram_din_o  = bus.din_i[sel];

   // Remember the parked address and who is owed read data next cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_hold_q <= '0;
         rd_pend_q   <= 1'b0;
         rd_owner_q  <= '0;
      end else begin
         if (any_gnt) begin
            addr_hold_q <= bus.addr_i[sel];
         end
         rd_pend_q  <= any_gnt & ~bus.we_i[sel];
         rd_owner_q <= sel;
      end
   end

   // Steer the RAM output to the owner; others see their last captured data.
   always_comb begin
      for (int p = 0; p < NUM_REQ; p++) begin
         rvalid[p]      = rd_pend_q && (rd_owner_q == req_idx_t'(p));
         bus.rdata_o[p] = rvalid[p] ? ram_dout_i : rdata_hold_q[p];
      end
   end

   assign bus.rvalid_o = rvalid;

   // Capture delivered read data so it stays visible between responses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_hold_q <= '0;
      end else begin
         for (int p = 0; p < NUM_REQ; p++) begin
            if (rvalid[p]) begin
               rdata_hold_q[p] <= ram_dout_i;
            end
         end
      end
   end

endmodule
`default_nettype wire
